// File: rtl/rsb_recovery_ctrl.sv
// Speculation controller for the return stack buffer: forwards predicted call/ret ops,
// journals them, and walks the RSB back on mispredict. Optional macro: RSB_RECOVERY_STATS_EN.
module rsb_recovery_ctrl #(
    parameter int JDEPTH    = 16,
    parameter int RSB_DEPTH = 32,
    parameter int AW        = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        call_i,
    input  logic [AW-1:0]               call_addr_i,
    input  logic                        ret_i,
    output logic                        ready_o,
    output logic [$clog2(JDEPTH):0]     jtail_o,
    input  logic                        commit_i,
    input  logic                        flush_i,
    input  logic [$clog2(JDEPTH):0]     flush_ptr_i,
    output logic                        recovering_o,
    output logic                        recover_done_o,
    output logic                        err_o,
    output logic                        rsb_push_o,
    output logic [AW-1:0]               rsb_push_addr_o,
    output logic                        rsb_pop_o,
    input  logic [AW-1:0]               rsb_top_i,
    output logic [15:0]                 stat_recov_o,
    output logic [15:0]                 stat_undo_o
);

    localparam int IW = $clog2(JDEPTH);
    localparam int PW = IW + 1;
    localparam int OW = $clog2(RSB_DEPTH + 1);

    typedef enum logic {IDLE, RECOVER} state_t;

    typedef struct packed {
        logic          is_pop;
        logic [AW-1:0] addr;
        logic          occ_sat;
    } jent_t;

    state_t          state;
    logic [PW-1:0]   head, tail, target;
    logic [OW-1:0]   occ;
    jent_t           journal [JDEPTH];

    logic [PW-1:0]   count, tail_m1, fdist, eff_target, walk_tgt;
    logic            flush_ok, flush_go, do_call, do_ret, undo_en, walk_active, commit_ok;
    jent_t           undo_ent;

    assign count    = tail - head;
    assign tail_m1  = tail - PW'(1);
    assign fdist    = flush_ptr_i - head;
    // Modular range check: flush_ptr_i lies in [head, tail] iff its distance from head fits in count.
    assign flush_ok = (fdist <= count);
    assign flush_go = flush_i && flush_ok;

    assign ready_o  = (state == IDLE) && (count < PW'(JDEPTH)) && !flush_i;
    assign do_call  = ready_o && call_i;
    assign do_ret   = ready_o && ret_i && !call_i && (occ != '0);

    assign eff_target = (state == RECOVER && flush_go) ? flush_ptr_i : target;
    assign undo_en    = (state == RECOVER) && (eff_target != tail);
    assign undo_ent   = journal[tail_m1[IW-1:0]];

    // Entries at or above the walk target belong to the walk and may not be retired.
    assign walk_tgt    = flush_go ? flush_ptr_i : target;
    assign walk_active = flush_go ? (flush_ptr_i != tail) : (state == RECOVER);
    assign commit_ok   = (count != '0) && !(walk_active && head == walk_tgt);

    assign rsb_push_o      = !rst && (do_call || (undo_en && undo_ent.is_pop));
    assign rsb_pop_o       = !rst && (do_ret || (undo_en && !undo_ent.is_pop));
    assign rsb_push_addr_o = rst ? '0 :
                             do_call ? call_addr_i :
                             (undo_en && undo_ent.is_pop) ? undo_ent.addr : '0;

    assign jtail_o      = tail;
    assign recovering_o = (state == RECOVER);

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (do_call)
                journal[tail[IW-1:0]] <= '{is_pop: 1'b0, addr: call_addr_i,
                                           occ_sat: (occ == OW'(RSB_DEPTH))};
            else if (do_ret)
                journal[tail[IW-1:0]] <= '{is_pop: 1'b1, addr: rsb_top_i, occ_sat: 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            head           <= '0;
            tail           <= '0;
            target         <= '0;
            occ            <= '0;
            recover_done_o <= 1'b0;
            err_o          <= 1'b0;
        end else begin
            recover_done_o <= 1'b0;
            err_o          <= (ready_o && call_i && ret_i) ||
                              (commit_i && !commit_ok) ||
                              (flush_i && !flush_ok);
            if (commit_i && commit_ok)
                head <= head + PW'(1);
            case (state)
                IDLE: begin
                    if (do_call) begin
                        tail <= tail + PW'(1);
                        if (occ != OW'(RSB_DEPTH))
                            occ <= occ + OW'(1);
                    end else if (do_ret) begin
                        tail <= tail + PW'(1);
                        occ  <= occ - OW'(1);
                    end
                    if (flush_go) begin
                        if (flush_ptr_i == tail) begin
                            recover_done_o <= 1'b1;
                        end else begin
                            target <= flush_ptr_i;
                            state  <= RECOVER;
                        end
                    end
                end
                RECOVER: begin
                    if (flush_go)
                        target <= flush_ptr_i;
                    if (!undo_en) begin
                        // Retargeted to the current tail: nothing left to undo.
                        state          <= IDLE;
                        recover_done_o <= 1'b1;
                    end else begin
                        tail <= tail_m1;
                        if (undo_ent.is_pop)
                            occ <= occ + OW'(1);
                        else if (!undo_ent.occ_sat)
                            occ <= occ - OW'(1);
                        if (tail_m1 == eff_target) begin
                            state          <= IDLE;
                            recover_done_o <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RSB_RECOVERY_STATS_EN
    logic [15:0] stat_recov, stat_undo;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_recov <= '0;
            stat_undo  <= '0;
        end else begin
            if (state == IDLE && flush_go && flush_ptr_i != tail && stat_recov != 16'hFFFF)
                stat_recov <= stat_recov + 16'd1;
            if (undo_en && stat_undo != 16'hFFFF)
                stat_undo <= stat_undo + 16'd1;
        end
    end

    assign stat_recov_o = stat_recov;
    assign stat_undo_o  = stat_undo;
`else
    assign stat_recov_o = '0;
    assign stat_undo_o  = '0;
`endif

endmodule

// File: tb/tb_rsb_recovery_ctrl.sv
// Directed bench for rsb_recovery_ctrl with a small behavioural RSB stack attached.
module tb_rsb_recovery_ctrl;

    localparam int JD = 16;
    localparam int RD = 32;
    localparam int AW = 64;
    localparam int PW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          call_i, ret_i, commit_i, flush_i;
    logic [AW-1:0] call_addr_i;
    logic [PW-1:0] flush_ptr_i;
    logic          ready_o, recovering_o, recover_done_o, err_o;
    logic [PW-1:0] jtail_o;
    logic          rsb_push_o, rsb_pop_o;
    logic [AW-1:0] rsb_push_addr_o, rsb_top_i;
    logic [15:0]   stat_recov_o, stat_undo_o;

    always #5 clk = ~clk;

    rsb_recovery_ctrl #(.JDEPTH(JD), .RSB_DEPTH(RD), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .call_i(call_i), .call_addr_i(call_addr_i), .ret_i(ret_i),
        .ready_o(ready_o), .jtail_o(jtail_o),
        .commit_i(commit_i), .flush_i(flush_i), .flush_ptr_i(flush_ptr_i),
        .recovering_o(recovering_o), .recover_done_o(recover_done_o), .err_o(err_o),
        .rsb_push_o(rsb_push_o), .rsb_push_addr_o(rsb_push_addr_o), .rsb_pop_o(rsb_pop_o),
        .rsb_top_i(rsb_top_i),
        .stat_recov_o(stat_recov_o), .stat_undo_o(stat_undo_o)
    );

    // Behavioural RSB driven by the controller's commands.
    logic [AW-1:0] stk [64];
    int            sp;

    always @(posedge clk) begin
        if (rst)
            sp <= 0;
        else if (rsb_push_o && sp < 64) begin
            stk[6'(sp)] <= rsb_push_addr_o;
            sp          <= sp + 1;
        end else if (rsb_pop_o && sp > 0)
            sp <= sp - 1;
    end

    assign rsb_top_i = (sp > 0) ? stk[6'(sp - 1)] : '0;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_in();
        call_i = 0; ret_i = 0; commit_i = 0; flush_i = 0;
        flush_ptr_i = '0; call_addr_i = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_in();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic do_call(input logic [63:0] a);
        call_i = 1; call_addr_i = a;
        #1;
        chk("call_push", rsb_push_o, 1);
        chk("call_addr", rsb_push_addr_o, a);
        tick();
        call_i = 0;
    endtask

    task automatic do_flush(input logic [PW-1:0] p);
        flush_i = 1; flush_ptr_i = p;
        #1;
        chk("flush_ready", ready_o, 0);
        tick();
        flush_i = 0;
    endtask

    task automatic wait_done(output int undos);
        undos = 0;
        for (int i = 0; i < 40 && !recover_done_o; i++) begin
            if (rsb_push_o || rsb_pop_o) undos++;
            tick();
        end
        chk("walk_done", recover_done_o, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: no summary reached");
        $fatal(1);
    end

    initial begin
        int u;
        logic [PW-1:0] snap;
        do_reset();

        chk("rst_ready", ready_o, 1);
        chk("rst_jtail", jtail_o, 0);
        chk("rst_recov", recovering_o, 0);
        chk("rst_done", recover_done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_push", rsb_push_o, 0);
        chk("rst_pop", rsb_pop_o, 0);
        chk("rst_stat_r", stat_recov_o, 0);
        chk("rst_stat_u", stat_undo_o, 0);

        // 3 calls, 2 rets, flush back to snapshot
        do_call(64'hA); do_call(64'hB); do_call(64'hC);
        chk("t1_jtail3", jtail_o, 3);
        snap = jtail_o;
        for (int i = 0; i < 2; i++) begin
            ret_i = 1; #1;
            chk("t1_ret_pop", rsb_pop_o, 1);
            tick();
            ret_i = 0;
        end
        chk("t1_jtail5", jtail_o, 5);
        chk("t1_top_a", rsb_top_i, 64'hA);
        do_flush(snap);
        chk("t1_recov1", recovering_o, 1);
        chk("t1_undo1_push", rsb_push_o, 1);
        chk("t1_undo1_addr", rsb_push_addr_o, 64'hB);
        tick();
        chk("t1_undo2_push", rsb_push_o, 1);
        chk("t1_undo2_addr", rsb_push_addr_o, 64'hC);
        tick();
        chk("t1_recov0", recovering_o, 0);
        chk("t1_done", recover_done_o, 1);
        chk("t1_ready", ready_o, 1);
        chk("t1_jtail", jtail_o, 3);
        chk("t1_top_c", rsb_top_i, 64'hC);
        tick();
        chk("t1_done_pulse", recover_done_o, 0);

        // flush to current tail: no walk, done next cycle
        do_flush(5'd3);
        chk("ft_done", recover_done_o, 1);
        chk("ft_recov", recovering_o, 0);
        chk("ft_jtail", jtail_o, 3);

        // ret with empty occupancy model
        do_reset();
        ret_i = 1; #1;
        chk("t3_no_pop", rsb_pop_o, 0);
        tick();
        ret_i = 0;
        chk("t3_jtail", jtail_o, 0);
        chk("t3_err", err_o, 0);

        // journal full
        do_reset();
        for (int i = 0; i < 16; i++) do_call(64'h100 + 64'(i));
        chk("t2_ready0", ready_o, 0);
        chk("t2_jtail16", jtail_o, 16);
        call_i = 1; call_addr_i = 64'h999; commit_i = 1; #1;
        chk("t2_drop", rsb_push_o, 0);
        tick();
        call_i = 0; commit_i = 0;
        chk("t2_ready1", ready_o, 1);
        chk("t2_jtail", jtail_o, 16);

        // walk of 5 retargeted after 2 undos
        do_reset();
        for (int i = 0; i < 5; i++) do_call(64'h10 + 64'(i));
        do_flush(5'd0);
        chk("t4_u1", rsb_pop_o, 1);
        tick();
        chk("t4_u2", rsb_pop_o, 1);
        tick();
        chk("t4_jtail3", jtail_o, 3);
        flush_i = 1; flush_ptr_i = 5'd1; #1;
        chk("t4_u3", rsb_pop_o, 1);
        tick();
        flush_i = 0;
        chk("t4_recov", recovering_o, 1);
        chk("t4_u4", rsb_pop_o, 1);
        tick();
        chk("t4_recov0", recovering_o, 0);
        chk("t4_done", recover_done_o, 1);
        chk("t4_jtail1", jtail_o, 1);
        chk("t4_sp", sp, 1);
        chk("t4_top", rsb_top_i, 64'h10);

        // illegal requests
        commit_i = 1; tick(); commit_i = 0;
        chk("t5_commit_ok", err_o, 0);
        do_flush(5'd0);
        chk("t5_flush_err", err_o, 1);
        chk("t5_flush_recov", recovering_o, 0);
        chk("t5_flush_jtail", jtail_o, 1);
        tick();
        chk("t5_err_pulse", err_o, 0);
        call_i = 1; ret_i = 1; call_addr_i = 64'h55; #1;
        chk("t5_cr_push", rsb_push_o, 1);
        chk("t5_cr_pop", rsb_pop_o, 0);
        tick();
        call_i = 0; ret_i = 0;
        chk("t5_cr_err", err_o, 1);
        chk("t5_cr_jtail", jtail_o, 2);
        chk("t5_cr_top", rsb_top_i, 64'h55);
        commit_i = 1; tick();
        chk("t5_commit2_ok", err_o, 0);
        tick(); commit_i = 0;
        chk("t5_commit_empty", err_o, 1);

        // statistics
        do_reset();
        for (int i = 0; i < 3; i++) do_call(64'h20 + 64'(i));
        do_flush(5'd0);
        wait_done(u);
        chk("t6_undo3", u, 3);
        tick();
        for (int i = 0; i < 4; i++) do_call(64'h30 + 64'(i));
        do_flush(5'd0);
        wait_done(u);
        chk("t6_undo4", u, 4);
`ifdef RSB_RECOVERY_STATS_EN
        chk("t6_stat_recov", stat_recov_o, 2);
        chk("t6_stat_undo", stat_undo_o, 7);
`else
        chk("t6_stat_recov", stat_recov_o, 0);
        chk("t6_stat_undo", stat_undo_o, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
